main_controller: RTL and testbench

MAIN_CONTROLLER -- requirements
Module: main_controller

---
 rtl/main_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_main_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/main_controller.sv
// Multi-cycle RV32 main controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// registered Moore outputs decoded from the state and the opcode/funct3 latched in DECODE.
module main_controller #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       run_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output logic       pc_en_o,
    output logic [1:0] pc_select_o,
    output logic       reg_write_o,
    output logic       alu_src_o,
    output logic       ram_rd_en_o,
    output logic       ram_wr_en_o,
    output logic       is_byte_o,
    output logic       is_half_o,
    output logic       is_word_o,
    output logic [1:0] mem_to_reg_o,
    output logic       halted_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [3:0] LastCnt = 4'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic [2:0] f3_q, f3_d;
    logic [3:0] cnt_q, cnt_d;
    logic       halted_q, halted_d;

    logic       pc_en_q, pc_en_d;
    logic [1:0] pc_sel_q, pc_sel_d;
    logic       reg_write_q, reg_write_d;
    logic       alu_src_q, alu_src_d;
    logic       rd_en_q, rd_en_d;
    logic       wr_en_q, wr_en_d;
    logic       byte_q, byte_d;
    logic       half_q, half_d;
    logic       word_q, word_d;
    logic [1:0] m2r_q, m2r_d;

    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OpLoad:  is_legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            OpStore: is_legal = (f3 inside {3'b000, 3'b001, 3'b010});
            OpR, OpI, OpBranch, OpJal, OpJalr, OpLui: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        f3_d     = f3_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        case (state_q)
            StFetch: begin
                if (run_i) state_d = StDecode;
            end
            StDecode: begin
                op_d = opcode_i;
                f3_d = funct3_i;
                if (is_legal(opcode_i, funct3_i)) begin
                    state_d = StExec;
                end else begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end
            end
            StExec: begin
                cnt_d = 4'd0;
                case (op_q)
                    OpLoad, OpStore:  state_d = StMem;
                    OpR, OpI, OpLui:  state_d = StWb;
                    default:          state_d = StFetch;
                endcase
            end
            StMem: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = 4'd0;
                    state_d = (op_q == OpLoad) ? StWb : StFetch;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Outputs are decoded from the next-state values so the registered copies
    // line up with the state they describe.
    always_comb begin
        pc_en_d     = 1'b0;
        pc_sel_d    = 2'b00;
        reg_write_d = 1'b0;
        alu_src_d   = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        byte_d      = 1'b0;
        half_d      = 1'b0;
        word_d      = 1'b0;
        m2r_d       = 2'b00;
        case (state_d)
            StExec: begin
                case (op_d)
                    OpI, OpLoad, OpStore: alu_src_d = 1'b1;
                    OpBranch: begin
                        pc_en_d  = 1'b1;
                        pc_sel_d = 2'b01;
                    end
                    OpJal: begin
                        reg_write_d = 1'b1;
                        m2r_d       = 2'b10;
                        pc_en_d     = 1'b1;
                        pc_sel_d    = 2'b10;
                    end
                    OpJalr: begin
                        reg_write_d = 1'b1;
                        m2r_d       = 2'b10;
                        alu_src_d   = 1'b1;
                        pc_en_d     = 1'b1;
                        pc_sel_d    = 2'b11;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                alu_src_d = 1'b1;
                rd_en_d   = (op_d == OpLoad);
                wr_en_d   = (op_d == OpStore);
                case (f3_d[1:0])
                    2'b00:   byte_d = 1'b1;
                    2'b01:   half_d = 1'b1;
                    2'b10:   word_d = 1'b1;
                    default: ;
                endcase
                // A store retires on its last MEM cycle.
                if (op_d == OpStore && cnt_d == LastCnt) pc_en_d = 1'b1;
            end
            StWb: begin
                reg_write_d = 1'b1;
                pc_en_d     = 1'b1;
                if (op_d == OpLoad)     m2r_d = 2'b01;
                else if (op_d == OpLui) m2r_d = 2'b11;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= StFetch;
            op_q        <= 7'd0;
            f3_q        <= 3'd0;
            cnt_q       <= 4'd0;
            halted_q    <= 1'b0;
            pc_en_q     <= 1'b0;
            pc_sel_q    <= 2'b00;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            byte_q      <= 1'b0;
            half_q      <= 1'b0;
            word_q      <= 1'b0;
            m2r_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            f3_q        <= f3_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
            pc_en_q     <= pc_en_d;
            pc_sel_q    <= pc_sel_d;
            reg_write_q <= reg_write_d;
            alu_src_q   <= alu_src_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            byte_q      <= byte_d;
            half_q      <= half_d;
            word_q      <= word_d;
            m2r_q       <= m2r_d;
        end
    end

    assign pc_en_o      = pc_en_q;
    assign pc_select_o  = pc_sel_q;
    assign reg_write_o  = reg_write_q;
    assign alu_src_o    = alu_src_q;
    assign ram_rd_en_o  = rd_en_q;
    assign ram_wr_en_o  = wr_en_q;
    assign is_byte_o    = byte_q;
    assign is_half_o    = half_q;
    assign is_word_o    = word_q;
    assign mem_to_reg_o = m2r_q;
    assign halted_o     = halted_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_main_controller.sv
// Directed bench for main_controller: one instance at MEM_LAT=3 driven from a vector
// table, one at MEM_LAT=1 checked with hand-written store/load sequences.
module tb_main_controller;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpLd    = 7'b0000011;
    localparam logic [6:0] OpSt    = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    logic       clk;
    logic       reset;
    logic       run;
    logic [6:0] opcode;
    logic [2:0] funct3;

    logic       a_pe, a_rw, a_alu, a_rd, a_wr, a_b, a_h, a_w, a_hl;
    logic [1:0] a_ps, a_m2r;
    logic [2:0] a_st;
    logic       b_pe, b_rw, b_alu, b_rd, b_wr, b_b, b_h, b_w, b_hl;
    logic [1:0] b_ps, b_m2r;
    logic [2:0] b_st;

    main_controller #(.MEM_LAT(3)) dut_a (
        .clk_i(clk), .reset_i(reset), .run_i(run), .opcode_i(opcode), .funct3_i(funct3),
        .pc_en_o(a_pe), .pc_select_o(a_ps), .reg_write_o(a_rw), .alu_src_o(a_alu),
        .ram_rd_en_o(a_rd), .ram_wr_en_o(a_wr), .is_byte_o(a_b), .is_half_o(a_h),
        .is_word_o(a_w), .mem_to_reg_o(a_m2r), .halted_o(a_hl), .state_o(a_st)
    );

    main_controller #(.MEM_LAT(1)) dut_b (
        .clk_i(clk), .reset_i(reset), .run_i(run), .opcode_i(opcode), .funct3_i(funct3),
        .pc_en_o(b_pe), .pc_select_o(b_ps), .reg_write_o(b_rw), .alu_src_o(b_alu),
        .ram_rd_en_o(b_rd), .ram_wr_en_o(b_wr), .is_byte_o(b_b), .is_half_o(b_h),
        .is_word_o(b_w), .mem_to_reg_o(b_m2r), .halted_o(b_hl), .state_o(b_st)
    );

    // {state, pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn, isByte, isHalf, isWord,
    //  memToReg, halted}
    wire [15:0] a_out = {a_st, a_pe, a_ps, a_rw, a_alu, a_rd, a_wr, a_b, a_h, a_w, a_m2r, a_hl};
    wire [15:0] b_out = {b_st, b_pe, b_ps, b_rw, b_alu, b_rd, b_wr, b_b, b_h, b_w, b_m2r, b_hl};

    typedef struct {
        logic       rst_n;
        logic       run;
        logic [6:0] op;
        logic [2:0] f3;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ex(input logic [2:0] st, input logic pe,
                                       input logic [1:0] ps, input logic rw, input logic al,
                                       input logic rd, input logic wr, input logic b,
                                       input logic h, input logic w, input logic [1:0] m2r,
                                       input logic hl);
        return {st, pe, ps, rw, al, rd, wr, b, h, w, m2r, hl};
    endfunction

    function automatic logic [15:0] z(input logic [2:0] st);
        return {st, 13'd0};
    endfunction

    function automatic vec_t mk(input logic r, input logic rn, input logic [6:0] op,
                                input logic [2:0] f3, input logic [15:0] e);
        vec_t v;
        v.rst_n = r;
        v.run   = rn;
        v.op    = op;
        v.f3    = f3;
        v.exp   = e;
        return v;
    endfunction

    task automatic step(input logic r, input logic rn, input logic [6:0] op,
                        input logic [2:0] f3);
        reset  = r;
        run    = rn;
        opcode = op;
        funct3 = f3;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        run = 1'b0;
        opcode = 7'd0;
        funct3 = 3'd0;

        // R-type: 0,1,2,4,0 (first row is the reset state)
        vecs.push_back(mk(0, 1, OpR, 0, z(0)));
        vecs.push_back(mk(1, 1, OpR, 0, z(1)));
        vecs.push_back(mk(1, 1, OpR, 0, z(2)));
        vecs.push_back(mk(1, 1, OpR, 0, ex(4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpR, 0, z(0)));
        // run=0 stalls FETCH; run=0 mid-instruction does not stall I-ALU
        vecs.push_back(mk(1, 0, OpI, 0, z(0)));
        vecs.push_back(mk(1, 0, OpI, 0, z(0)));
        vecs.push_back(mk(1, 1, OpI, 0, z(1)));
        vecs.push_back(mk(1, 0, OpI, 0, ex(2, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0)));
        vecs.push_back(mk(1, 0, OpI, 0, ex(4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpI, 0, z(0)));
        // LOAD funct3=100 with three MEM cycles
        vecs.push_back(mk(1, 1, OpLd, 3'b100, z(1)));
        vecs.push_back(mk(1, 1, OpLd, 3'b100, ex(2, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0)));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 1, OpLd, 3'b100,
                              ex(3, 0, 2'b00, 0, 1, 1, 0, 1, 0, 0, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpLd, 3'b100, ex(4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0)));
        vecs.push_back(mk(1, 1, OpLd, 3'b100, z(0)));
        // LUI
        vecs.push_back(mk(1, 1, OpLui, 0, z(1)));
        vecs.push_back(mk(1, 1, OpLui, 0, z(2)));
        vecs.push_back(mk(1, 1, OpLui, 0, ex(4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b11, 0)));
        vecs.push_back(mk(1, 1, OpLui, 0, z(0)));
        // BRANCH, JAL, JALR retire in EXEC
        vecs.push_back(mk(1, 1, OpBr, 0, z(1)));
        vecs.push_back(mk(1, 1, OpBr, 0, ex(2, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpBr, 0, z(0)));
        vecs.push_back(mk(1, 1, OpJal, 0, z(1)));
        vecs.push_back(mk(1, 1, OpJal, 0, ex(2, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0)));
        vecs.push_back(mk(1, 1, OpJal, 0, z(0)));
        vecs.push_back(mk(1, 1, OpJalr, 0, z(1)));
        vecs.push_back(mk(1, 1, OpJalr, 0, ex(2, 1, 2'b11, 1, 1, 0, 0, 0, 0, 0, 2'b10, 0)));
        vecs.push_back(mk(1, 1, OpJalr, 0, z(0)));
        // STORE word, three MEM cycles, retires on the last one
        vecs.push_back(mk(1, 1, OpSt, 3'b010, z(1)));
        vecs.push_back(mk(1, 1, OpSt, 3'b010, ex(2, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpSt, 3'b010, ex(3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 1, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpSt, 3'b010, ex(3, 0, 2'b00, 0, 1, 0, 1, 0, 0, 1, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpSt, 3'b010, ex(3, 1, 2'b00, 0, 1, 0, 1, 0, 0, 1, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpSt, 3'b010, z(0)));
        // Illegal opcode -> sticky HALT, cleared only by reset
        vecs.push_back(mk(1, 1, OpAuipc, 0, z(1)));
        vecs.push_back(mk(1, 1, OpAuipc, 0, 16'd1 | {3'd5, 13'd0}));
        vecs.push_back(mk(1, 0, OpAuipc, 0, 16'd1 | {3'd5, 13'd0}));
        vecs.push_back(mk(1, 1, OpR, 0, 16'd1 | {3'd5, 13'd0}));
        vecs.push_back(mk(0, 1, OpR, 0, z(0)));
        // Illegal STORE and LOAD funct3
        vecs.push_back(mk(1, 1, OpSt, 3'b011, z(1)));
        vecs.push_back(mk(1, 1, OpSt, 3'b011, 16'd1 | {3'd5, 13'd0}));
        vecs.push_back(mk(0, 1, OpSt, 3'b011, z(0)));
        vecs.push_back(mk(1, 1, OpLd, 3'b011, z(1)));
        vecs.push_back(mk(1, 1, OpLd, 3'b011, 16'd1 | {3'd5, 13'd0}));
        vecs.push_back(mk(0, 1, OpLd, 3'b011, z(0)));
        // Reset during the second MEM cycle of a halfword load: no writeback follows
        vecs.push_back(mk(1, 1, OpLd, 3'b001, z(1)));
        vecs.push_back(mk(1, 1, OpLd, 3'b001, ex(2, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpLd, 3'b001, ex(3, 0, 2'b00, 0, 1, 1, 0, 0, 1, 0, 2'b00, 0)));
        vecs.push_back(mk(1, 1, OpLd, 3'b001, ex(3, 0, 2'b00, 0, 1, 1, 0, 0, 1, 0, 2'b00, 0)));
        vecs.push_back(mk(0, 1, OpLd, 3'b001, z(0)));
        vecs.push_back(mk(1, 0, OpLd, 3'b001, z(0)));
        vecs.push_back(mk(1, 0, OpLd, 3'b001, z(0)));

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].run, vecs[i].op, vecs[i].f3);
            chk($sformatf("vec%0d", i), a_out, vecs[i].exp);
        end

        // MEM_LAT=1 store halfword: one MEM cycle carrying the retire
        step(0, 1, OpSt, 3'b001);
        chk("b_reset", b_out, z(0));
        step(1, 1, OpSt, 3'b001);
        chk("b_st_decode", b_out, z(1));
        step(1, 1, OpSt, 3'b001);
        chk("b_st_exec", b_out, ex(2, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
        step(1, 1, OpSt, 3'b001);
        chk("b_st_mem", b_out, ex(3, 1, 2'b00, 0, 1, 0, 1, 0, 1, 0, 2'b00, 0));
        step(1, 0, OpSt, 3'b001);
        chk("b_st_fetch", b_out, z(0));

        // MEM_LAT=1 load halfword unsigned (funct3=101)
        step(1, 1, OpLd, 3'b101);
        chk("b_ld_decode", b_out, z(1));
        step(1, 1, OpLd, 3'b101);
        chk("b_ld_exec", b_out, ex(2, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));
        step(1, 1, OpLd, 3'b101);
        chk("b_ld_mem", b_out, ex(3, 0, 2'b00, 0, 1, 1, 0, 0, 1, 0, 2'b00, 0));
        step(1, 0, OpLd, 3'b101);
        chk("b_ld_wb", b_out, ex(4, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b01, 0));
        step(1, 0, OpLd, 3'b101);
        chk("b_ld_fetch", b_out, z(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
